// File: rtl/profile_accumulator.sv
// Folded pulse-profile histogram: counts hits per phase bin in a synchronous-read RAM,
// with a clear sweep and a streamed dump. Define PROFILE_ACC_SAT_EN for saturating counts.
module profile_accumulator #(
    parameter int unsigned BIN_W    = 10,
    parameter int unsigned NUM_BINS = 1024,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit_valid,
    input  logic [BIN_W-1:0] hit_bin,
    output logic             hit_ready,
    input  logic             clear_start,
    input  logic             dump_start,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [BIN_W-1:0] dump_bin,
    output logic [CNT_W-1:0] dump_count,
    output logic             dump_last,
    output logic             busy,
    output logic             sat_flag
);

    typedef enum logic [1:0] {StClear, StAccum, StDump} state_e;

    state_e             r_state;
    logic [BIN_W-1:0]   r_clr_ptr;
    logic               r_clr_pend;
    logic               r_dump_pend;

    logic               r_p_valid;
    logic [BIN_W-1:0]   r_p_bin;
    logic               r_wb_valid;
    logic [BIN_W-1:0]   r_wb_bin;
    logic [CNT_W-1:0]   r_wb_data;

    logic [BIN_W:0]     r_rd_ptr;
    logic               r_rdv;
    logic [BIN_W-1:0]   r_rd_bin;

    logic               r_dump_valid;
    logic [BIN_W-1:0]   r_dump_bin;
    logic [CNT_W-1:0]   r_dump_count;
    logic               r_dump_last;
    logic               r_sat_flag;

    logic [CNT_W-1:0]   r_mem [NUM_BINS];
    logic [CNT_W-1:0]   r_rd_data;

    logic               w_hit_ready;
    logic               w_accept;
    logic               w_load;
    logic               w_dump_rd;
    logic               w_rd_en;
    logic [BIN_W-1:0]   w_rd_addr;
    logic [CNT_W-1:0]   w_base;
    logic [CNT_W-1:0]   w_new;
    logic               w_sat;
    logic               w_we;
    logic [BIN_W-1:0]   w_wr_addr;
    logic [CNT_W-1:0]   w_wr_data;

    assign w_hit_ready = (r_state == StAccum) && !r_clr_pend && !r_dump_pend;
    assign w_accept    = hit_valid && w_hit_ready;

    // Dump read stage refills only when the output register will have room for it.
    assign w_load    = r_rdv && (!r_dump_valid || dump_ready);
    assign w_dump_rd = (r_state == StDump) && (r_rd_ptr < (BIN_W + 1)'(NUM_BINS))
                       && (!r_rdv || w_load);

    assign w_rd_en   = w_accept || w_dump_rd;
    assign w_rd_addr = (r_state == StDump) ? r_rd_ptr[BIN_W-1:0] : hit_bin;

    // The write landing on the same edge as this bin's read is not seen by the RAM read.
    assign w_base = (r_wb_valid && (r_wb_bin == r_p_bin)) ? r_wb_data : r_rd_data;

    always_comb begin
        w_sat = 1'b0;
        w_new = w_base + CNT_W'(1);
`ifdef PROFILE_ACC_SAT_EN
        if (w_base == {CNT_W{1'b1}}) begin
            w_sat = 1'b1;
            w_new = w_base;
        end
`endif
    end

    always_comb begin
        w_we      = 1'b0;
        w_wr_addr = r_p_bin;
        w_wr_data = w_new;
        if (r_state == StClear) begin
            w_we      = 1'b1;
            w_wr_addr = r_clr_ptr;
            w_wr_data = '0;
        end else if (r_p_valid) begin
            w_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StClear;
            r_clr_ptr    <= '0;
            r_clr_pend   <= 1'b0;
            r_dump_pend  <= 1'b0;
            r_p_valid    <= 1'b0;
            r_p_bin      <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_bin     <= '0;
            r_wb_data    <= '0;
            r_rd_ptr     <= '0;
            r_rdv        <= 1'b0;
            r_rd_bin     <= '0;
            r_dump_valid <= 1'b0;
            r_dump_bin   <= '0;
            r_dump_count <= '0;
            r_dump_last  <= 1'b0;
            r_sat_flag   <= 1'b0;
        end else begin
            r_p_valid  <= w_accept;
            if (w_accept) begin
                r_p_bin <= hit_bin;
            end
            r_wb_valid <= r_p_valid;
            if (r_p_valid) begin
                r_wb_bin  <= r_p_bin;
                r_wb_data <= w_new;
                if (w_sat) begin
                    r_sat_flag <= 1'b1;
                end
            end

            if (w_dump_rd) begin
                r_rd_bin <= r_rd_ptr[BIN_W-1:0];
                r_rd_ptr <= r_rd_ptr + (BIN_W + 1)'(1);
                r_rdv    <= 1'b1;
            end else if (w_load) begin
                r_rdv <= 1'b0;
            end

            if (w_load) begin
                r_dump_valid <= 1'b1;
                r_dump_bin   <= r_rd_bin;
                r_dump_count <= r_rd_data;
                r_dump_last  <= (r_rd_bin == BIN_W'(NUM_BINS - 1));
            end else if (r_dump_valid && dump_ready) begin
                r_dump_valid <= 1'b0;
            end

            unique case (r_state)
                StClear: begin
                    r_clr_ptr <= r_clr_ptr + BIN_W'(1);
                    if (r_clr_ptr == BIN_W'(NUM_BINS - 1)) begin
                        r_state <= StAccum;
                    end
                end
                StAccum: begin
                    if (clear_start) begin
                        r_clr_pend  <= 1'b1;
                        r_dump_pend <= 1'b0;
                    end else if (dump_start && !r_clr_pend) begin
                        r_dump_pend <= 1'b1;
                    end
                    // Leave only once the last accepted hit has been written back.
                    if ((r_clr_pend || r_dump_pend) && !r_p_valid) begin
                        r_clr_pend  <= 1'b0;
                        r_dump_pend <= 1'b0;
                        if (r_clr_pend || clear_start) begin
                            r_state    <= StClear;
                            r_clr_ptr  <= '0;
                            r_sat_flag <= 1'b0;
                        end else begin
                            r_state  <= StDump;
                            r_rd_ptr <= '0;
                            r_rdv    <= 1'b0;
                        end
                    end
                end
                StDump: begin
                    if (clear_start) begin
                        r_state      <= StClear;
                        r_clr_ptr    <= '0;
                        r_rdv        <= 1'b0;
                        r_dump_valid <= 1'b0;
                        r_sat_flag   <= 1'b0;
                    end else if (r_dump_valid && dump_ready && r_dump_last) begin
                        r_state <= StAccum;
                    end
                end
                default: begin
                    r_state   <= StClear;
                    r_clr_ptr <= '0;
                end
            endcase
        end
    end

    assign hit_ready  = w_hit_ready;
    assign dump_valid = r_dump_valid;
    assign dump_bin   = r_dump_bin;
    assign dump_count = r_dump_count;
    assign dump_last  = r_dump_last;
    assign busy       = (r_state != StAccum) || r_p_valid;
    assign sat_flag   = r_sat_flag;

endmodule

// File: tb/tb_profile_accumulator.sv
// Self-checking bench for profile_accumulator (16 bins, 4-bit counts) against a per-bin
// count array; honours PROFILE_ACC_SAT_EN when the build defines it.
module tb_profile_accumulator;

    localparam int BW   = 4;
    localparam int NB   = 16;
    localparam int CW   = 4;
    localparam int MAXC = 15;

    logic          clk;
    logic          rst;
    logic          hit_valid;
    logic [BW-1:0] hit_bin;
    logic          hit_ready;
    logic          clear_start;
    logic          dump_start;
    logic          dump_valid;
    logic          dump_ready;
    logic [BW-1:0] dump_bin;
    logic [CW-1:0] dump_count;
    logic          dump_last;
    logic          busy;
    logic          sat_flag;

    int vectors = 0;
    int errors  = 0;
    int model [NB];
    bit sat_m = 1'b0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    profile_accumulator #(
        .BIN_W    (BW),
        .NUM_BINS (NB),
        .CNT_W    (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hit_valid   (hit_valid),
        .hit_bin     (hit_bin),
        .hit_ready   (hit_ready),
        .clear_start (clear_start),
        .dump_start  (dump_start),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_bin    (dump_bin),
        .dump_count  (dump_count),
        .dump_last   (dump_last),
        .busy        (busy),
        .sat_flag    (sat_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) model[i] = 0;
        sat_m = 1'b0;
    endtask

    task automatic model_inc(input int b);
`ifdef PROFILE_ACC_SAT_EN
        if (model[b] == MAXC) sat_m = 1'b1;
        else model[b] = model[b] + 1;
`else
        model[b] = (model[b] + 1) % (MAXC + 1);
`endif
    endtask

    task automatic hit_cycle(input logic v, input int b, input bit chk);
        hit_valid = v;
        hit_bin   = BW'(b);
        if (chk) check("hit_ready_high", hit_ready, 1);
        if (v && hit_ready) model_inc(b);
        step();
        hit_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hit_ready"}, hit_ready, 0);
        check({tag, "_dump_valid"}, dump_valid, 0);
        check({tag, "_dump_last"}, dump_last, 0);
        check({tag, "_dump_bin"}, dump_bin, 0);
        check({tag, "_dump_count"}, dump_count, 0);
        check({tag, "_sat_flag"}, sat_flag, 0);
        check({tag, "_busy"}, busy, 1);
    endtask

    // Counts sampled cycles with hit_ready low, starting from the current sample.
    task automatic count_clear(input string tag);
        int n = 0;
        while (hit_ready !== 1'b1 && n < 40) begin
            n++;
            step();
        end
        check({tag, "_clear_cycles"}, n, NB);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic do_dump(input bit tog, input string tag);
        int idx = 0;
        int k = 0;
        int cyc = 0;
        bit done = 1'b0;
        bit prev_stall = 1'b0;
        bit rdy;
        logic [BW-1:0] pb = '0;
        logic [CW-1:0] pc = '0;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        check({tag, "_ready_drop"}, hit_ready, 0);
        while (!done && cyc < 200) begin
            if (prev_stall) begin
                check({tag, "_stall_valid"}, dump_valid, 1);
                check({tag, "_stall_bin"}, dump_bin, pb);
                check({tag, "_stall_count"}, dump_count, pc);
            end
            rdy = tog ? pat[k % 4] : 1'b1;
            dump_ready = rdy;
            if (dump_valid) begin
                check({tag, "_bin"}, dump_bin, idx);
                check({tag, "_count"}, dump_count, (idx < NB) ? model[idx] : 32'hdead);
                check({tag, "_last"}, dump_last, (idx == NB - 1) ? 1 : 0);
                k++;
                prev_stall = !rdy;
                pb = dump_bin;
                pc = dump_count;
                if (rdy) begin
                    if (idx == NB - 1) done = 1'b1;
                    idx++;
                end
            end else begin
                prev_stall = 1'b0;
            end
            step();
            cyc++;
        end
        dump_ready = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_valid_after"}, dump_valid, 0);
        check({tag, "_ready_after"}, hit_ready, 1);
        check({tag, "_sat_flag"}, sat_flag, sat_m);
    endtask

    initial begin
        bit dv;
        int n;
        rst = 1'b0;
        hit_valid = 1'b0;
        hit_bin = '0;
        clear_start = 1'b0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        model_clear();
        #2 rst = 1'b1;
        step();
        check_reset_vals("reset");
        step();
        rst = 1'b0;
        count_clear("reset");
        do_dump(1'b0, "zero_dump");

        for (int i = 0; i < 4; i++) hit_cycle(1'b1, 5, 1'b1);
        hit_cycle(1'b1, 9, 1'b1);
        wait_idle("fwd");
        do_dump(1'b0, "fwd_dump");

        hit_cycle(1'b1, 3, 1'b1);
        hit_cycle(1'b1, 3, 1'b1);
        hit_cycle(1'b1, 7, 1'b1);
        hit_cycle(1'b1, 3, 1'b1);
        wait_idle("alt");
        do_dump(1'b0, "alt_dump");

        for (int i = 0; i < 150; i++) begin
            hit_cycle(logic'($urandom_range(0, 1)), int'($urandom_range(0, NB - 1)), 1'b0);
        end
        wait_idle("rand");
        do_dump(1'b1, "stall_dump");
        do_dump(1'b0, "redump");

        for (int i = 0; i < 10; i++) hit_cycle(1'b1, int'($urandom_range(0, NB - 1)), 1'b1);
        dump_start = 1'b1;
        clear_start = 1'b1;
        step();
        dump_start = 1'b0;
        clear_start = 1'b0;
        dv = 1'b0;
        n = 0;
        while (hit_ready !== 1'b1 && n < 60) begin
            if (dump_valid) dv = 1'b1;
            step();
            n++;
        end
        check("both_no_dump", dv, 0);
        check("both_ready_back", hit_ready, 1);
        model_clear();
        do_dump(1'b0, "after_clear_dump");

        for (int i = 0; i < 17; i++) hit_cycle(1'b1, 2, 1'b1);
        wait_idle("sat");
        do_dump(1'b0, "sat_dump");

        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        repeat (6) step();
        check("abort_pre_valid", dump_valid, 1);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        dump_ready = 1'b0;
        check("abort_valid_drop", dump_valid, 0);
        count_clear("abort");
        model_clear();
        do_dump(1'b0, "abort_dump");

        for (int i = 0; i < 8; i++) hit_cycle(1'b1, int'($urandom_range(0, NB - 1)), 1'b1);
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        #1;
        check_reset_vals("midreset");
        dump_ready = 1'b0;
        step();
        rst = 1'b0;
        count_clear("midreset");
        model_clear();
        do_dump(1'b0, "final_dump");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
